// File: rtl/hrm_pkg.sv
// ============================================================================
// Module      : hrm_pkg
// Description : Shared constants, FSM state encoding and opcode decode helper
//               for the program fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hrm_pkg;

  // Opcode / operand byte width
  localparam int c_OPCODE_W = 8;

  // Opcodes whose upper nibble falls in [c_OPND_LO, c_OPND_HI] carry one operand byte
  localparam logic [3:0] c_OPND_LO = 4'h2;
  localparam logic [3:0] c_OPND_HI = 4'hA;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPC     = 3'd1,
    S_OPND_RD = 3'd2,
    S_OPND    = 3'd3,
    S_DONE    = 3'd4
  } fetchState_t;

  // Decode on the opcode's upper nibble only; the low nibble never affects length
  function automatic logic hasOperand(input logic [3:0] opHi);
    return (opHi >= c_OPND_LO) && (opHi <= c_OPND_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pfetch_pc.sv
// ============================================================================
// Module      : pfetch_pc
// Description : Program counter with jump load and increment. With
//               PFETCH_OVF_HALT_EN defined, an increment from all-ones holds
//               the counter and sets a sticky overflow flag; otherwise the
//               counter wraps and the flag is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfetch_pc #(
  parameter int PROG_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PROG_ADDR_W-1:0] loadAddr,
  input  logic                   inc,
  output logic [PROG_ADDR_W-1:0] pc,
  output logic                   ovf
);

  logic [PROG_ADDR_W-1:0] r_pc;

`ifdef PFETCH_OVF_HALT_EN
  logic r_ovf;

  // Load has priority over increment; saturate at all-ones and flag it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_pc <= loadAddr;
    end else if (inc) begin
      if (&r_pc) begin
        r_ovf <= 1'b1;
      end else begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
`else
  // Load has priority over increment; increment wraps modulo 2^PROG_ADDR_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= loadAddr;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign ovf = 1'b0;
`endif

  assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/prog_fetch.sv
// ============================================================================
// Module      : prog_fetch
// Description : Instruction fetch sequencer. Reads an opcode byte from a
//               synchronous program memory, optionally reads one operand byte,
//               and pulses IR / operand / done strobes. Optional feature macro:
//               PFETCH_OVF_HALT_EN (PC saturates, sticky overflow halts fetch).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_fetch
  import hrm_pkg::*;
#(
  parameter int PROG_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic                   jmp_en,
  input  logic [PROG_ADDR_W-1:0] jmp_addr,
  output logic [PROG_ADDR_W-1:0] pmem_addr,
  input  logic [c_OPCODE_W-1:0]  pmem_data,
  output logic [c_OPCODE_W-1:0]  nIR,
  output logic                   wIR,
  output logic [c_OPCODE_W-1:0]  param,
  output logic                   wParam,
  output logic [PROG_ADDR_W-1:0] pc,
  output logic                   fetch_busy,
  output logic                   fetch_done,
  output logic                   pc_ovf
);

  fetchState_t             r_state;
  logic                    r_wIR;
  logic                    r_wParam;
  logic                    r_fetchDone;
  logic                    r_busy;
  logic [c_OPCODE_W-1:0]   r_param;

  logic                    w_pcLoad;
  logic                    w_pcInc;
  logic [PROG_ADDR_W-1:0]  w_pc;
  logic                    w_ovf;

  // Jumps only land in IDLE; the PC advances after each opcode and operand byte
  assign w_pcLoad = (r_state == S_IDLE) && jmp_en;
  assign w_pcInc  = (r_state == S_OPC) || (r_state == S_OPND);

  pfetch_pc #(
    .PROG_ADDR_W (PROG_ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (w_pcLoad),
    .loadAddr (jmp_addr),
    .inc      (w_pcInc),
    .pc       (w_pc),
    .ovf      (w_ovf)
  );

  // Fetch sequencer; strobes are registered so they line up with their state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wIR       <= 1'b0;
      r_wParam    <= 1'b0;
      r_fetchDone <= 1'b0;
      r_busy      <= 1'b0;
      r_param     <= '0;
    end else begin
      r_wIR       <= 1'b0;
      r_wParam    <= 1'b0;
      r_fetchDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A jump in the same cycle wins over the fetch request
          if (fetch_req && !jmp_en && !w_ovf) begin
            r_state <= S_OPC;
            r_wIR   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_OPC: begin
          if (hasOperand(pmem_data[7:4])) begin
            r_state <= S_OPND_RD;
          end else begin
            r_state     <= S_DONE;
            r_fetchDone <= 1'b1;
          end
        end
        S_OPND_RD: begin
          // Memory is reading the incremented PC this cycle
          r_state <= S_OPND;
        end
        S_OPND: begin
          r_param     <= pmem_data;
          r_state     <= S_DONE;
          r_wParam    <= 1'b1;
          r_fetchDone <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_addr  = w_pc;
  assign pc         = w_pc;
  assign nIR        = pmem_data;
  assign wIR        = r_wIR;
  assign param      = r_param;
  assign wParam     = r_wParam;
  assign fetch_busy = r_busy;
  assign fetch_done = r_fetchDone;
  assign pc_ovf     = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_prog_fetch.sv
// ============================================================================
// Module      : tb_prog_fetch
// Description : Directed self-checking bench for prog_fetch with a behavioural
//               synchronous program memory. Expected values follow the
//               PFETCH_OVF_HALT_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_fetch;

  logic       clk;
  logic       rst;
  logic       fetch_req;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] pmem_addr;
  logic [7:0] pmem_data;
  logic [7:0] nIR;
  logic       wIR;
  logic [7:0] param;
  logic       wParam;
  logic [7:0] pc;
  logic       fetch_busy;
  logic       fetch_done;
  logic       pc_ovf;

  logic [7:0] mem [256];

  int nVec;
  int nMiss;

  prog_fetch #(
    .PROG_ADDR_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .pmem_addr  (pmem_addr),
    .pmem_data  (pmem_data),
    .nIR        (nIR),
    .wIR        (wIR),
    .param      (param),
    .wParam     (wParam),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .pc_ovf     (pc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read memory: data valid one cycle after the address edge
  always @(posedge clk) pmem_data <= mem[pmem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nVec      = 0;
    nMiss     = 0;
    rst       = 1'b1;
    fetch_req = 1'b0;
    jmp_en    = 1'b0;
    jmp_addr  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC3;
    mem[0]     = 8'h00;
    mem[1]     = 8'h25;
    mem[2]     = 8'h07;
    mem[8'h40] = 8'h11;
    mem[8'hFF] = 8'h00;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_pc",     pc,         0);
    chk("rst_param",  param,      0);
    chk("rst_busy",   fetch_busy, 0);
    chk("rst_wIR",    wIR,        0);
    chk("rst_wParam", wParam,     0);
    chk("rst_done",   fetch_done, 0);
    chk("rst_ovf",    pc_ovf,     0);

    // No-operand fetch from pc=0
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f0_wIR",   wIR,        1);
    chk("f0_nIR",   nIR,        8'h00);
    chk("f0_busy",  fetch_busy, 1);
    chk("f0_done1", fetch_done, 0);
    step();
    chk("f0_done",   fetch_done, 1);
    chk("f0_wParam", wParam,     0);
    chk("f0_pc",     pc,         1);
    chk("f0_wIR2",   wIR,        0);
    step();
    chk("f0_idle_busy", fetch_busy, 0);
    chk("f0_idle_done", fetch_done, 0);

    // Operand fetch from pc=1; extra request during OPND_RD is dropped
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f1_wIR", wIR, 1);
    chk("f1_nIR", nIR, 8'h25);
    step();
    chk("f1_rd_wIR",  wIR,        0);
    chk("f1_rd_done", fetch_done, 0);
    chk("f1_rd_pc",   pc,         2);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("f1_op_done",   fetch_done, 0);
    chk("f1_op_wParam", wParam,     0);
    chk("f1_op_wIR",    wIR,        0);
    step();
    chk("f1_wParam", wParam,     1);
    chk("f1_param",  param,      8'h07);
    chk("f1_done",   fetch_done, 1);
    chk("f1_pc",     pc,         3);
    step();
    chk("f1_post_done",   fetch_done, 0);
    chk("f1_post_wParam", wParam,     0);
    chk("f1_post_busy",   fetch_busy, 0);
    step();
    chk("f1_noqueue_wIR",  wIR,        0);
    chk("f1_noqueue_busy", fetch_busy, 0);

    // Jump wins over simultaneous fetch request
    jmp_en    = 1'b1;
    jmp_addr  = 8'h40;
    fetch_req = 1'b1;
    step();
    jmp_en    = 1'b0;
    fetch_req = 1'b0;
    chk("jmp_pc",    pc,         8'h40);
    chk("jmp_wIR",   wIR,        0);
    chk("jmp_busy",  fetch_busy, 0);
    chk("jmp_param", param,      8'h07);
    step();
    chk("jmp_wIR2",  wIR,        0);
    chk("jmp_busy2", fetch_busy, 0);

    // Reset in OPND_RD
    jmp_en   = 1'b1;
    jmp_addr = 8'h01;
    step();
    jmp_en    = 1'b0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("mr_wIR", wIR, 1);
    step();
    chk("mr_pc_rd", pc, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_pc",     pc,         0);
    chk("mr_param",  param,      0);
    chk("mr_wParam", wParam,     0);
    chk("mr_done",   fetch_done, 0);
    chk("mr_busy",   fetch_busy, 0);
    step();
    chk("mr_wParam2", wParam,     0);
    chk("mr_done2",   fetch_done, 0);
    chk("mr_busy2",   fetch_busy, 0);

    // PC overflow at all-ones
    jmp_en   = 1'b1;
    jmp_addr = 8'hFF;
    step();
    jmp_en    = 1'b0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("ov_wIR", wIR, 1);
    chk("ov_nIR", nIR, 8'h00);
    step();
    chk("ov_done", fetch_done, 1);
`ifdef PFETCH_OVF_HALT_EN
    chk("ov_pc",  pc,     8'hFF);
    chk("ov_flg", pc_ovf, 1);
`else
    chk("ov_pc",  pc,     8'h00);
    chk("ov_flg", pc_ovf, 0);
`endif
    step();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
`ifdef PFETCH_OVF_HALT_EN
    chk("ov_refetch_wIR",  wIR,        0);
    chk("ov_refetch_busy", fetch_busy, 0);
    chk("ov_refetch_flg",  pc_ovf,     1);
`else
    chk("ov_refetch_wIR",  wIR,        1);
    chk("ov_refetch_busy", fetch_busy, 1);
    chk("ov_refetch_flg",  pc_ovf,     0);
`endif
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ov_rst_flg", pc_ovf, 0);
    chk("ov_rst_pc",  pc,     0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

`default_nettype wire
